// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner-locked arbiter feeding one UART TX core
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   req_valid/last    per-lane byte valid and end-of-message flag
//   req_data          packed lane bytes, lane i at [8i+7:8i]
//   req_ready         combinational accept, only the owner lane while the UART is free
//   tx_data/tx_start  byte and one-cycle start pulse to the UART TX core
//   tx_busy           UART TX core is shifting a byte
//   grant_id/active   current owner index and ownership flag
//   timeout_err       one-cycle pulse when a stalled owner is released
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_WAIT    = 4,
    parameter int HOLD_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [1:0]           grant_id,
    output logic                 grant_active,
    output logic                 timeout_err
);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT_HI, WAIT_LO} state_t;
    state_t state, state_n;
    logic [1:0] rr_ptr, rr_ptr_n, grant_id_n, sel, idx, next_ptr;
    logic [2:0] sum, busy_cnt, busy_cnt_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic [7:0] tx_data_n;
    logic grant_active_n, tx_start_n, timeout_err_n, last_q, last_q_n, found, hs;

    // Scan from the farthest lane back toward rr_ptr so the nearest valid lane wins.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + 3'(k);
            idx = 2'(sum >= 3'(NUM_REQ) ? sum - 3'(NUM_REQ) : sum);
            if (req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
    assign hs       = (state == GRANT) && req_valid[grant_id] && !tx_busy;

    always_comb begin
        req_ready = '0;
        if (state == GRANT && !tx_busy) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_n        = state;
        rr_ptr_n       = rr_ptr;
        grant_id_n     = grant_id;
        grant_active_n = grant_active;
        tx_data_n      = tx_data;
        tx_start_n     = 1'b0;
        timeout_err_n  = 1'b0;
        last_q_n       = last_q;
        hold_cnt_n     = hold_cnt;
        busy_cnt_n     = busy_cnt;
        case (state)
            IDLE: if (found) begin
                grant_id_n     = sel;
                grant_active_n = 1'b1;
                hold_cnt_n     = '0;
                state_n        = GRANT;
            end
            GRANT: if (hs) begin
                tx_data_n  = req_data[{grant_id, 3'b000} +: 8];
                tx_start_n = 1'b1;
                last_q_n   = req_last[grant_id];
                hold_cnt_n = '0;
                busy_cnt_n = '0;
                state_n    = WAIT_HI;
            end else if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                // This idle cycle brings the count to HOLD_TIMEOUT.
                timeout_err_n  = 1'b1;
                rr_ptr_n       = next_ptr;
                grant_active_n = 1'b0;
                hold_cnt_n     = '0;
                state_n        = IDLE;
            end else begin
                hold_cnt_n = hold_cnt + 1'b1;
            end
            WAIT_HI: if (tx_busy || busy_cnt == 3'(BUSY_WAIT - 1)) state_n = WAIT_LO;
                     else busy_cnt_n = busy_cnt + 3'd1;
            WAIT_LO: if (!tx_busy) begin
                if (last_q) begin
                    rr_ptr_n       = next_ptr;
                    grant_active_n = 1'b0;
                    state_n        = IDLE;
                end else begin
                    state_n = GRANT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            timeout_err  <= 1'b0;
            last_q       <= 1'b0;
            hold_cnt     <= '0;
            busy_cnt     <= '0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_ptr_n;
            grant_id     <= grant_id_n;
            grant_active <= grant_active_n;
            tx_data      <= tx_data_n;
            tx_start     <= tx_start_n;
            timeout_err  <= timeout_err_n;
            last_q       <= last_q_n;
            hold_cnt     <= hold_cnt_n;
            busy_cnt     <= busy_cnt_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the UART TX arbiter with lane queues and a UART busy model
module tb_uart_tx_arbiter;
    logic clk = 1'b0, rst_n = 1'b0, tx_busy = 1'b0;
    logic [3:0] req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic [7:0] tx_data;
    logic tx_start, grant_active, timeout_err;
    logic [1:0] grant_id;

    uart_tx_arbiter #(.NUM_REQ(4), .BUSY_WAIT(4), .HOLD_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
        .grant_active(grant_active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int prev; logic [3:0] mask; logic [1:0] exp; } vec_t;
    vec_t tbl[6];
    logic [8:0] mem[4][32];
    int wr[4], rd[4];
    int total = 0, bad = 0, ucnt = 0, ready_viol = 0, id_viol = 0, watch_id = 0;
    bit watch_on = 0, ga_q = 0;
    logic [3:0] fired = '0;
    logic [9:0] log_q[$];
    logic [1:0] gnt_q[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(int l, logic [7:0] b, logic last);
        mem[l][wr[l] % 32] = {last, b};
        wr[l]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < 4; i++) if (rd[i] != wr[i]) return 1;
        return grant_active || tx_busy;
    endfunction

    // One cycle: UART model and lane drivers update at negedge, samples taken 1 time unit later.
    task automatic step();
        @(negedge clk);
        if (tx_start) ucnt = 10;
        else if (ucnt != 0) ucnt--;
        tx_busy = (ucnt != 0);
        for (int i = 0; i < 4; i++) begin
            if (fired[i]) rd[i]++;
            req_valid[i] = (rd[i] != wr[i]);
            req_data[8*i +: 8] = mem[i][rd[i] % 32][7:0];
            req_last[i] = mem[i][rd[i] % 32][8];
        end
        #1;
        fired = req_valid & req_ready;
        if (tx_start) log_q.push_back({grant_id, tx_data});
        if (grant_active && !ga_q) gnt_q.push_back(grant_id);
        ga_q = grant_active;
        if (req_ready[2] && (grant_id != 2 || log_q.size() < 3)) ready_viol++;
        if (watch_on && grant_active && grant_id != 2'(watch_id)) id_viol++;
    endtask

    task automatic drain(string nm);
        int n = 0;
        while (pending() && n < 600) begin
            step();
            n++;
        end
        chk({nm, " drain"}, 32'(pending()), 0);
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) rd[i] = wr[i];
        fired = '0;
        req_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        step();
        step();
        rst_n = 1'b1;
        step();
        log_q.delete();
        gnt_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] sb[4];
        tbl[0] = '{0, 4'b0110, 2'd1};
        tbl[1] = '{1, 4'b0011, 2'd0};
        tbl[2] = '{3, 4'b1001, 2'd0};
        tbl[3] = '{2, 4'b1101, 2'd3};
        tbl[4] = '{1, 4'b0100, 2'd2};
        tbl[5] = '{0, 4'b1111, 2'd1};
        sb[0] = 8'h31; sb[1] = 8'h32; sb[2] = 8'h33; sb[3] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end

        step();
        step();
        chk("rst tx_data", 32'(tx_data), 0);
        chk("rst tx_start", 32'(tx_start), 0);
        chk("rst grant_id", 32'(grant_id), 0);
        chk("rst grant_active", 32'(grant_active), 0);
        chk("rst timeout_err", 32'(timeout_err), 0);
        chk("rst req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        step();

        // Single requester on lane 1, with latency checks on the first byte.
        log_q.delete();
        gnt_q.delete();
        watch_id = 1;
        watch_on = 1;
        id_viol = 0;
        for (int i = 0; i < 4; i++) push(1, sb[i], i == 3);
        step();
        step();
        chk("latency grant_active", 32'(grant_active), 1);
        chk("latency tx_start early", 32'(tx_start), 0);
        step();
        chk("latency tx_start", 32'(tx_start), 1);
        chk("latency tx_data", 32'(tx_data), 32'h31);
        drain("single");
        watch_on = 0;
        chk("single count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk($sformatf("single byte%0d", i), 32'(log_q[i]), 32'({2'd1, sb[i]}));
        chk("single grant_id steady", id_viol, 0);
        chk("single grant released", 32'(grant_active), 0);

        // Contention on lanes 0 and 2 from reset.
        do_reset();
        ready_viol = 0;
        for (int i = 0; i < 3; i++) begin
            push(0, 8'h61 + 8'(i), i == 2);
            push(2, 8'h71 + 8'(i), i == 2);
        end
        drain("contend");
        chk("contend count", log_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < log_q.size())
                chk($sformatf("contend byte%0d", i), 32'(log_q[i]),
                    32'(i < 3 ? {2'd0, 8'h61 + 8'(i)} : {2'd2, 8'h71 + 8'(i - 3)}));
        chk("contend ready2 held low", ready_viol, 0);

        // Round-robin fairness between lanes 0 and 1.
        do_reset();
        push(0, 8'h10, 1); push(0, 8'h11, 1);
        push(1, 8'h20, 1); push(1, 8'h21, 1);
        drain("fair");
        chk("fair grants", gnt_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_q.size()) chk($sformatf("fair grant%0d", i), 32'(gnt_q[i]), i % 2);
        if (log_q.size() == 4) chk("fair byte3", 32'(log_q[3]), 32'({2'd1, 8'h21}));

        // Table: set rr_ptr by completing a message on prev, then request a lane set together.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            push(tbl[t].prev, 8'h80 + 8'(t), 1);
            drain($sformatf("tbl%0d prev", t));
            gnt_q.delete();
            for (int i = 0; i < 4; i++) if (tbl[t].mask[i]) push(i, 8'h90 + 8'(i), 1);
            drain($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d first grant", t), 32'(gnt_q.size() > 0 ? gnt_q[0] : 2'bxx), 32'(tbl[t].exp));
            chk($sformatf("tbl%0d grants", t), gnt_q.size(), $countones(tbl[t].mask));
        end

        // Hold timeout: lane 0 stalls after a non-last byte while lane 1 waits.
        do_reset();
        push(0, 8'h41, 0);
        push(1, 8'h42, 1);
        n = 0;
        while (!tx_busy && n < 50) begin step(); n++; end
        while (tx_busy && n < 50) begin step(); n++; end
        chk("timeout busy seen", 32'(n < 50), 1);
        n = 0;
        do begin step(); n++; end while (!timeout_err && n < 30);
        chk("timeout delay", n, 9);
        chk("timeout released", 32'(grant_active), 0);
        step();
        chk("timeout pulse width", 32'(timeout_err), 0);
        chk("timeout next active", 32'(grant_active), 1);
        chk("timeout next id", 32'(grant_id), 1);
        drain("timeout");
        chk("timeout log", log_q.size(), 2);
        if (log_q.size() == 2) chk("timeout lane1 byte", 32'(log_q[1]), 32'({2'd1, 8'h42}));

        // Reset asserted mid-message while waiting for the UART to finish.
        do_reset();
        push(2, 8'h55, 0); push(2, 8'h66, 0); push(2, 8'h77, 1);
        n = 0;
        while (!(log_q.size() >= 1 && tx_busy) && n < 50) begin step(); n++; end
        chk("midrst owner", 32'(grant_id), 2);
        chk("midrst data", 32'(tx_data), 32'h55);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst grant_active", 32'(grant_active), 0);
        chk("midrst grant_id", 32'(grant_id), 0);
        chk("midrst tx_data", 32'(tx_data), 0);
        chk("midrst tx_start", 32'(tx_start), 0);
        chk("midrst timeout_err", 32'(timeout_err), 0);
        chk("midrst req_ready", 32'(req_ready), 0);
        flush();
        step();
        rst_n = 1'b1;
        gnt_q.delete();
        for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1);
        drain("midrst");
        chk("midrst first grant", 32'(gnt_q.size() > 0 ? gnt_q[0] : 2'bxx), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
